vfirst_reduce: RTL and testbench

//  Multi-chunk reducer for vfirst.m. Consumes the registered per-chunk result (found flag + absolute

---
 rtl/vfirst_reduce_if.sv | 35 +++
 rtl/vfirst_reduce.sv | 104 ++++++++++
 tb/tb_vfirst_reduce.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vfirst_reduce_if.sv
// rtl/vfirst_reduce_if.sv - chunk-result / scalar-result bundle for the vfirst.m reducer
// Purpose: groups the per-chunk input stream and the scalar result outputs of vfirst_reduce.
// Signals:
//   in_valid  chunk result valid this cycle
//   in_start  first chunk of an instruction (qualified by in_valid)
//   in_end    last chunk of an instruction (qualified by in_valid)
//   in_found  chunk contained a set mask bit
//   in_idx    absolute element index of the first set bit in the chunk
//   out_valid one-cycle result pulse
//   out_data  zero-extended index, or all-ones when no bit was found
//   busy      instruction in progress
// Modports: master = first-bit stage side (drives chunks), slave = reducer side.
interface vfirst_reduce_if #(
   parameter int RESP_DATA_WIDTH = 64,
   parameter int IDX_BITS        = 10
);
   logic                       in_valid;
   logic                       in_start;
   logic                       in_end;
   logic                       in_found;
   logic [IDX_BITS-1:0]        in_idx;
   logic                       out_valid;
   logic [RESP_DATA_WIDTH-1:0] out_data;
   logic                       busy;

   modport master (
      output in_valid, in_start, in_end, in_found, in_idx,
      input  out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_start, in_end, in_found, in_idx,
      output out_valid, out_data, busy
   );
endinterface

// File: rtl/vfirst_reduce.sv
// rtl/vfirst_reduce.sv - multi-chunk reducer producing the vfirst.m scalar result
// Purpose: consumes one registered first-set-bit chunk result per cycle across a mask register
//   and emits one scalar per instruction: the lowest set element index, or -1 if none.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  vfirst_reduce_if.slave: in_valid/in_start/in_end/in_found/in_idx chunk stream in,
//        out_valid/out_data result out, busy status out
// Configuration macro: VFIRST_EARLY_OUT_EN
//   defined   - result is emitted the cycle after the first beat that finds a set bit; the
//               rest of the instruction is swallowed up to in_end. Not-found reports at in_end.
//   undefined - result is emitted only the cycle after the in_end beat.
module vfirst_reduce #(
   parameter int RESP_DATA_WIDTH = 64,
   parameter int IDX_BITS        = 10
) (
   input  logic          clk,
   input  logic          rst,
   vfirst_reduce_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,   // no set bit seen yet
      HOLD = 2'd2    // set bit captured; later chunks cannot displace it
   } state_t;

   state_t              state;
   logic [IDX_BITS-1:0] hold_idx;
   logic                found;

   function automatic logic [RESP_DATA_WIDTH-1:0] fmt_result(input logic f,
                                                             input logic [IDX_BITS-1:0] idx);
      if (f) return {{(RESP_DATA_WIDTH-IDX_BITS){1'b0}}, idx};
      return {RESP_DATA_WIDTH{1'b1}};
   endfunction

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         hold_idx      <= '0;
         found         <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         if (bus.in_valid && bus.in_start) begin
            // A start beat always begins a fresh instruction, discarding any in flight.
            found    <= bus.in_found;
            hold_idx <= bus.in_idx;
            if (bus.in_end) begin
               bus.out_valid <= 1'b1;
               bus.out_data  <= fmt_result(bus.in_found, bus.in_idx);
               state         <= IDLE;
            end else begin
               state <= bus.in_found ? HOLD : SCAN;
`ifdef VFIRST_EARLY_OUT_EN
               if (bus.in_found) begin
                  bus.out_valid <= 1'b1;
                  bus.out_data  <= fmt_result(1'b1, bus.in_idx);
               end
`endif
            end
         end else if (bus.in_valid) begin
            case (state)
               SCAN: begin
                  if (bus.in_found) begin
                     found    <= 1'b1;
                     hold_idx <= bus.in_idx;
                     if (bus.in_end) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= fmt_result(1'b1, bus.in_idx);
                        state         <= IDLE;
                     end else begin
                        state <= HOLD;
`ifdef VFIRST_EARLY_OUT_EN
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= fmt_result(1'b1, bus.in_idx);
`endif
                     end
                  end else if (bus.in_end) begin
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= fmt_result(1'b0, bus.in_idx);
                     state         <= IDLE;
                  end
               end
               HOLD: begin
                  if (bus.in_end) begin
                     state <= IDLE;
`ifndef VFIRST_EARLY_OUT_EN
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= fmt_result(found, hold_idx);
`endif
                  end
               end
               default: ;   // IDLE: beats without start are not part of any instruction
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vfirst_reduce.sv
// tb/tb_vfirst_reduce.sv - directed and randomized self-checking bench for vfirst_reduce
module tb_vfirst_reduce;
   localparam int W  = 64;
   localparam int IB = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vfirst_reduce_if #(.RESP_DATA_WIDTH(W), .IDX_BITS(IB)) ifc ();

   vfirst_reduce #(.RESP_DATA_WIDTH(W), .IDX_BITS(IB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: an instruction is the list of its chunks; the answer is the first
   // found chunk's index, else -1.
   typedef struct {
      bit            f;
      logic [IB-1:0] idx;
   } chunk_t;
   chunk_t         q[$];
   bit             active    = 0;
   bit             reported  = 0;
   bit             exp_valid = 0;
   logic [W-1:0]   last_data = '0;

   function automatic logic [W-1:0] first_found();
      foreach (q[i]) if (q[i].f) return {{(W-IB){1'b0}}, q[i].idx};
      return {W{1'b1}};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic emit(input logic [W-1:0] d);
      exp_valid = 1;
      last_data = d;
   endtask

   task automatic model_beat(input bit v, input bit s, input bit e, input bit f,
                             input logic [IB-1:0] idx);
      chunk_t c;
      exp_valid = 0;
      if (!v) return;
      if (s) begin
         q.delete();
         active   = 1;
         reported = 0;
      end
      if (!active) return;
      c.f   = f;
      c.idx = idx;
      q.push_back(c);
`ifdef VFIRST_EARLY_OUT_EN
      if (f && !reported) begin
         emit(first_found());
         reported = 1;
      end
`endif
      if (e) begin
         if (!reported) emit(first_found());
         active = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, {63'd0, ifc.out_valid}, {63'd0, exp_valid});
      chk({tag, ".out_data"},  ifc.out_data, last_data);
      chk({tag, ".busy"},      {63'd0, ifc.busy}, {63'd0, active});
   endtask

   task automatic beat(input string tag, input bit v, input bit s, input bit e, input bit f,
                       input logic [IB-1:0] idx);
      @(negedge clk);
      ifc.in_valid = v;
      ifc.in_start = s;
      ifc.in_end   = e;
      ifc.in_found = f;
      ifc.in_idx   = idx;
      model_beat(v, s, e, f, idx);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst          = 1'b1;
      ifc.in_valid = 1'b1;
      ifc.in_start = 1'b0;
      ifc.in_end   = 1'b1;
      ifc.in_found = 1'b1;
      ifc.in_idx   = 10'd9;
      q.delete();
      active    = 0;
      reported  = 0;
      exp_valid = 0;
      last_data = '0;
      @(posedge clk);
      #1;
      check_outputs(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit            v, s, e, f;
      logic [IB-1:0] idx;
      int            r;

      ifc.in_valid = 0;
      ifc.in_start = 0;
      ifc.in_end   = 0;
      ifc.in_found = 0;
      ifc.in_idx   = '0;

      do_reset("reset");

      // single chunk start&end, found idx=5
      beat("t1", 1, 1, 1, 1, 10'd5);
      chk("t1_result", ifc.out_data, 64'd5);
      beat("t1_idle", 0, 0, 0, 0, 10'd0);

      // four chunks; first find in chunk 2 must survive chunk 3's find
      beat("t2_c0", 1, 1, 0, 0, 10'd11);
      beat("t2_c1", 1, 0, 0, 0, 10'd12);
      beat("t2_c2", 1, 0, 0, 1, 10'd130);
      beat("t2_c3", 1, 0, 1, 1, 10'd200);
      chk("t2_result", ifc.out_data, 64'd130);
      beat("t2_idle", 0, 0, 0, 0, 10'd0);

      // four chunks none found, bubbles between beats
      beat("t3_c0", 1, 1, 0, 0, 10'd1);
      beat("t3_b0", 0, 0, 0, 1, 10'd2);
      beat("t3_c1", 1, 0, 0, 0, 10'd3);
      beat("t3_b1", 0, 0, 1, 1, 10'd4);
      beat("t3_c2", 1, 0, 0, 0, 10'd5);
      beat("t3_c3", 1, 0, 1, 0, 10'd6);
      chk("t3_result", ifc.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      beat("t3_idle", 0, 0, 0, 0, 10'd0);

      // restart mid-instruction: only the new instruction reports
      beat("t4_c0", 1, 1, 0, 0, 10'd0);
      beat("t4_c1", 1, 0, 0, 0, 10'd0);
      beat("t4_rs", 1, 1, 1, 1, 10'd7);
      chk("t4_result", ifc.out_data, 64'd7);
      beat("t4_idle", 0, 0, 0, 0, 10'd0);

      // reset while holding, then a fresh single-chunk instruction
      beat("t5_c0", 1, 1, 0, 1, 10'd44);
      beat("t5_c1", 1, 0, 0, 0, 10'd45);
      do_reset("t5_rst");
      beat("t5_new", 1, 1, 1, 1, 10'd3);
      chk("t5_result", ifc.out_data, 64'd3);

      // back-to-back instructions, results on consecutive cycles
      beat("bb_a", 1, 1, 1, 0, 10'd8);
      beat("bb_b", 1, 1, 1, 1, 10'd1023);
      beat("bb_c0", 1, 1, 0, 0, 10'd0);
      beat("bb_c1", 1, 0, 1, 1, 10'd600);

      // chunk without start while idle is ignored
      beat("ign", 1, 0, 1, 1, 10'd77);

`ifdef VFIRST_EARLY_OUT_EN
      beat("t6_c0", 1, 1, 0, 1, 10'd2);
      chk("t6_early", ifc.out_data, 64'd2);
      beat("t6_c1", 1, 0, 0, 1, 10'd9);
      beat("t6_c2", 1, 0, 0, 0, 10'd9);
      beat("t6_c3", 1, 0, 1, 1, 10'd9);
`endif

      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_reset("rnd_rst");
         end else begin
            v   = ($urandom_range(0, 9) < 7);
            s   = ($urandom_range(0, 9) == 0) || (!active && $urandom_range(0, 1) == 1);
            e   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 3) == 0);
            idx = IB'($urandom);
            beat("rnd", v, s, e, f, idx);
         end
      end

      beat("drain", 0, 0, 0, 0, 10'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
